// File: rtl/ervp_cache_lpixm_arbiter_pkg.sv
// Shared types, policy encodings and arbitration helper for the cache LPIXM arbiter.
package ervp_cache_lpixm_arbiter_pkg;

   localparam int unsigned CACHE_ARB_POLICY_RR    = 0;
   localparam int unsigned CACHE_ARB_POLICY_FIXED = 1;

   localparam int unsigned DEF_BW_QDATA    = 128;
   localparam int unsigned DEF_BW_YDATA    = 35;
   localparam int unsigned DEF_ORDER_DEPTH = 4;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // Two-way pick: a single valid requester always wins; a tie goes to policy.
   function automatic logic arb_pick(input logic v0, input logic v1,
                                     input logic rr_last, input logic fixed);
      logic pick;
      if (v0 && v1) pick = fixed ? 1'b0 : ~rr_last;
      else          pick = v1;
      return pick;
   endfunction

endpackage

// File: rtl/ervp_cache_arb_order_fifo.sv
// 1-bit order FIFO remembering which requester issued each outstanding transaction.
module ervp_cache_arb_order_fifo
   import ervp_cache_lpixm_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_ORDER_DEPTH
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic push,
   input  logic push_id,
   input  logic pop,
   output logic head_id,
   output logic full,
   output logic empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head_id = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_id;
   end

endmodule

// File: rtl/ervp_cache_lpixm_arbiter.sv
// Shares one downstream LPIXM port between the cacheable (r0) and uncacheable (r1) paths,
// locking on multi-beat requests and routing replies back in issue order.
module ervp_cache_lpixm_arbiter
   import ervp_cache_lpixm_arbiter_pkg::*;
#(
   parameter int unsigned BW_QDATA    = DEF_BW_QDATA,
   parameter int unsigned BW_YDATA    = DEF_BW_YDATA,
   parameter int unsigned ORDER_DEPTH = DEF_ORDER_DEPTH,
   parameter int unsigned ARB_POLICY  = CACHE_ARB_POLICY_RR
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                enable,
   output logic                busy,
   output logic                err_orphan_reply,

   output logic [1:0]          r0_qdready,
   input  logic                r0_qvalid,
   input  logic                r0_qhint,
   input  logic                r0_qlast,
   input  logic                r0_qafy,
   input  logic [BW_QDATA-1:0] r0_qdata,
   input  logic [1:0]          r0_ydready,
   output logic                r0_yvalid,
   output logic                r0_yhint,
   output logic                r0_ylast,
   output logic [BW_YDATA-1:0] r0_ydata,

   output logic [1:0]          r1_qdready,
   input  logic                r1_qvalid,
   input  logic                r1_qhint,
   input  logic                r1_qlast,
   input  logic                r1_qafy,
   input  logic [BW_QDATA-1:0] r1_qdata,
   input  logic [1:0]          r1_ydready,
   output logic                r1_yvalid,
   output logic                r1_yhint,
   output logic                r1_ylast,
   output logic [BW_YDATA-1:0] r1_ydata,

   input  logic [1:0]          s_qdready,
   output logic                s_qvalid,
   output logic                s_qhint,
   output logic                s_qlast,
   output logic                s_qafy,
   output logic [BW_QDATA-1:0] s_qdata,
   output logic [1:0]          s_ydready,
   input  logic                s_yvalid,
   input  logic                s_yhint,
   input  logic                s_ylast,
   input  logic [BW_YDATA-1:0] s_ydata
);

   localparam logic POLICY_FIXED = (ARB_POLICY == CACHE_ARB_POLICY_FIXED);

   arb_state_e state_q, state_d;
   logic       locked_id_q, locked_id_d;
   logic       rr_last_q, rr_last_d;
   logic       err_q, err_d;

   logic       fifo_push;
   logic       fifo_pop;
   logic       fifo_head;
   logic       fifo_full;
   logic       fifo_empty;

   logic       grant_id;
   logic       active;
   logic       beat_acc;

   ervp_cache_arb_order_fifo #(
      .DEPTH (ORDER_DEPTH)
   ) u_order_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .push    (fifo_push),
      .push_id (grant_id),
      .pop     (fifo_pop),
      .head_id (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         locked_id_q <= 1'b0;
         rr_last_q   <= 1'b1;
         err_q       <= 1'b0;
      end else if (clear) begin
         state_q     <= ARB_IDLE;
         locked_id_q <= 1'b0;
         rr_last_q   <= 1'b1;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         locked_id_q <= locked_id_d;
         rr_last_q   <= rr_last_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      locked_id_d = locked_id_q;
      rr_last_d   = rr_last_q;
      err_d       = err_q;
      fifo_push   = 1'b0;
      fifo_pop    = 1'b0;
      grant_id    = locked_id_q;
      active      = 1'b0;
      beat_acc    = 1'b0;
      r0_qdready  = 2'b00;
      r1_qdready  = 2'b00;
      s_qvalid    = 1'b0;
      s_qhint     = 1'b0;
      s_qlast     = 1'b0;
      s_qafy      = 1'b0;
      s_qdata     = '0;
      s_ydready   = 2'b00;
      r0_yvalid   = 1'b0;
      r1_yvalid   = 1'b0;
      r0_yhint    = s_yhint;
      r1_yhint    = s_yhint;
      r0_ylast    = s_ylast;
      r1_ylast    = s_ylast;
      r0_ydata    = s_ydata;
      r1_ydata    = s_ydata;

      // A locked transaction always proceeds; a new one needs enable and order-FIFO room.
      if (state_q == ARB_IDLE) begin
         grant_id = arb_pick(r0_qvalid, r1_qvalid, rr_last_q, POLICY_FIXED);
         active   = enable & ~fifo_full;
      end else begin
         active   = 1'b1;
      end
      active = active & ~rst;

      if (grant_id) begin
         s_qvalid = r1_qvalid & active;
         s_qhint  = r1_qhint;
         s_qlast  = r1_qlast;
         s_qafy   = r1_qafy;
         s_qdata  = r1_qdata;
         if (active) r1_qdready = s_qdready;
      end else begin
         s_qvalid = r0_qvalid & active;
         s_qhint  = r0_qhint;
         s_qlast  = r0_qlast;
         s_qafy   = r0_qafy;
         s_qdata  = r0_qdata;
         if (active) r0_qdready = s_qdready;
      end

      beat_acc = s_qvalid & s_qdready[0];
      if (beat_acc) begin
         if (state_q == ARB_IDLE) begin
            fifo_push = 1'b1;
            rr_last_d = grant_id;
            if (!s_qlast) begin
               state_d     = ARB_LOCKED;
               locked_id_d = grant_id;
            end
         end else if (s_qlast) begin
            state_d = ARB_IDLE;
         end
      end

      // Replies go to the oldest issuer; a reply with nothing outstanding is refused and flagged.
      if (!fifo_empty) begin
         if (fifo_head) begin
            r1_yvalid = s_yvalid;
            s_ydready = r1_ydready;
         end else begin
            r0_yvalid = s_yvalid;
            s_ydready = r0_ydready;
         end
         fifo_pop = s_yvalid & s_ydready[0] & s_ylast;
      end else if (s_yvalid) begin
         err_d = 1'b1;
      end
   end

   assign busy             = (state_q == ARB_LOCKED) | ~fifo_empty;
   assign err_orphan_reply = err_q;

endmodule

// File: tb/tb_ervp_cache_lpixm_arbiter.sv
// Directed bench for the LPIXM arbiter: round-robin instance plus a fixed-priority instance.
module tb_ervp_cache_lpixm_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, clear, enable;
   logic r0_qvalid, r0_qhint, r0_qlast, r0_qafy;
   logic r1_qvalid, r1_qhint, r1_qlast, r1_qafy;
   logic [127:0] r0_qdata, r1_qdata;
   logic [1:0] r0_ydready, r1_ydready, s_qdready;
   logic s_yvalid, s_yhint, s_ylast;
   logic [34:0] s_ydata;

   logic busy, err;
   logic [1:0] r0_qdready, r1_qdready, s_ydready;
   logic r0_yvalid, r0_yhint, r0_ylast, r1_yvalid, r1_yhint, r1_ylast;
   logic [34:0] r0_ydata, r1_ydata;
   logic s_qvalid, s_qhint, s_qlast, s_qafy;
   logic [127:0] s_qdata;

   logic fp_busy, fp_err;
   logic [1:0] fp_r0_qdready, fp_r1_qdready, fp_s_ydready;
   logic fp_r0_yvalid, fp_r0_yhint, fp_r0_ylast, fp_r1_yvalid, fp_r1_yhint, fp_r1_ylast;
   logic [34:0] fp_r0_ydata, fp_r1_ydata;
   logic fp_s_qvalid, fp_s_qhint, fp_s_qlast, fp_s_qafy;
   logic [127:0] fp_s_qdata;

   ervp_cache_lpixm_arbiter #(.ARB_POLICY(0)) dut (
      .clk(clk), .rst(rst), .clear(clear), .enable(enable),
      .busy(busy), .err_orphan_reply(err),
      .r0_qdready(r0_qdready), .r0_qvalid(r0_qvalid), .r0_qhint(r0_qhint),
      .r0_qlast(r0_qlast), .r0_qafy(r0_qafy), .r0_qdata(r0_qdata),
      .r0_ydready(r0_ydready), .r0_yvalid(r0_yvalid), .r0_yhint(r0_yhint),
      .r0_ylast(r0_ylast), .r0_ydata(r0_ydata),
      .r1_qdready(r1_qdready), .r1_qvalid(r1_qvalid), .r1_qhint(r1_qhint),
      .r1_qlast(r1_qlast), .r1_qafy(r1_qafy), .r1_qdata(r1_qdata),
      .r1_ydready(r1_ydready), .r1_yvalid(r1_yvalid), .r1_yhint(r1_yhint),
      .r1_ylast(r1_ylast), .r1_ydata(r1_ydata),
      .s_qdready(s_qdready), .s_qvalid(s_qvalid), .s_qhint(s_qhint),
      .s_qlast(s_qlast), .s_qafy(s_qafy), .s_qdata(s_qdata),
      .s_ydready(s_ydready), .s_yvalid(s_yvalid), .s_yhint(s_yhint),
      .s_ylast(s_ylast), .s_ydata(s_ydata)
   );

   ervp_cache_lpixm_arbiter #(.ARB_POLICY(1)) dut_fp (
      .clk(clk), .rst(rst), .clear(clear), .enable(enable),
      .busy(fp_busy), .err_orphan_reply(fp_err),
      .r0_qdready(fp_r0_qdready), .r0_qvalid(r0_qvalid), .r0_qhint(r0_qhint),
      .r0_qlast(r0_qlast), .r0_qafy(r0_qafy), .r0_qdata(r0_qdata),
      .r0_ydready(r0_ydready), .r0_yvalid(fp_r0_yvalid), .r0_yhint(fp_r0_yhint),
      .r0_ylast(fp_r0_ylast), .r0_ydata(fp_r0_ydata),
      .r1_qdready(fp_r1_qdready), .r1_qvalid(r1_qvalid), .r1_qhint(r1_qhint),
      .r1_qlast(r1_qlast), .r1_qafy(r1_qafy), .r1_qdata(r1_qdata),
      .r1_ydready(r1_ydready), .r1_yvalid(fp_r1_yvalid), .r1_yhint(fp_r1_yhint),
      .r1_ylast(fp_r1_ylast), .r1_ydata(fp_r1_ydata),
      .s_qdready(s_qdready), .s_qvalid(fp_s_qvalid), .s_qhint(fp_s_qhint),
      .s_qlast(fp_s_qlast), .s_qafy(fp_s_qafy), .s_qdata(fp_s_qdata),
      .s_ydready(fp_s_ydready), .s_yvalid(s_yvalid), .s_yhint(s_yhint),
      .s_ylast(s_ylast), .s_ydata(s_ydata)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; enable = 1'b1;
      r0_qvalid = 1'b1; r0_qhint = 1'b0; r0_qlast = 1'b1; r0_qafy = 1'b0; r0_qdata = 128'hA0;
      r1_qvalid = 1'b1; r1_qhint = 1'b0; r1_qlast = 1'b1; r1_qafy = 1'b0; r1_qdata = 128'hB1;
      r0_ydready = 2'b11; r1_ydready = 2'b11; s_qdready = 2'b11;
      s_yvalid = 1'b0; s_yhint = 1'b0; s_ylast = 1'b0; s_ydata = 35'h0;

      // Reset: outputs quiet even though both requesters are valid
      #2;
      chk("rst_s_qvalid", s_qvalid, 0);
      chk("rst_r0_qdready", r0_qdready, 0);
      chk("rst_r1_qdready", r1_qdready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);

      // Two single-beat reads: r0 first, then r1, replies in order
      step(); rst = 1'b0; #1;
      chk("t1_g0_r0", r0_qdready, 2'b11);
      chk("t1_g0_r1", r1_qdready, 2'b00);
      chk("t1_g0_data", s_qdata, 128'hA0);
      chk("t1_g0_valid", s_qvalid, 1);
      step(); #1;
      chk("t1_g1_r1", r1_qdready, 2'b11);
      chk("t1_g1_r0", r0_qdready, 2'b00);
      chk("t1_g1_data", s_qdata, 128'hB1);
      step(); r0_qvalid = 1'b0; r1_qvalid = 1'b0;
      s_yvalid = 1'b1; s_ylast = 1'b1; s_ydata = 35'h1234; #1;
      chk("t1_busy", busy, 1);
      chk("t1_y0_r0", r0_yvalid, 1);
      chk("t1_y0_r1", r1_yvalid, 0);
      chk("t1_y0_sready", s_ydready, 2'b11);
      chk("t1_y0_data", r0_ydata, 35'h1234);
      step(); #1;
      chk("t1_y1_r1", r1_yvalid, 1);
      chk("t1_y1_r0", r0_yvalid, 0);
      step(); s_yvalid = 1'b0; #1;
      chk("t1_busy_end", busy, 0);
      chk("t1_fp_busy_end", fp_busy, 0);

      // Both continuously valid, immediate replies: RR alternates, fixed always r0
      r0_qvalid = 1'b1; r1_qvalid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("alt%0d_r0", i), r0_qdready[0], (i % 2) == 0);
         chk($sformatf("alt%0d_r1", i), r1_qdready[0], (i % 2) == 1);
         chk($sformatf("alt%0d_fp_r0", i), fp_r0_qdready[0], 1);
         chk($sformatf("alt%0d_fp_r1", i), fp_r1_qdready[0], 0);
         if (i > 0) chk($sformatf("alt%0d_reply", i), r1_yvalid, ((i - 1) % 2) == 1);
         step(); s_yvalid = 1'b1; s_ylast = 1'b1;
      end
      r0_qvalid = 1'b0; r1_qvalid = 1'b0; #1;
      chk("alt_last_reply", r1_yvalid, 1);
      step(); s_yvalid = 1'b0; #1;
      chk("alt_busy_end", busy, 0);
      chk("alt_fp_busy_end", fp_busy, 0);

      // Order FIFO full: 4 issue, 5th stalls, issues the cycle after a pop
      r0_qvalid = 1'b1; r0_qlast = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1; chk($sformatf("full_issue%0d", i), s_qvalid, 1);
         step();
      end
      #1;
      chk("full_stall_valid", s_qvalid, 0);
      chk("full_stall_rdy", r0_qdready, 2'b00);
      chk("full_busy", busy, 1);
      s_yvalid = 1'b1; s_ylast = 1'b1; #1;
      chk("full_pop_cycle_valid", s_qvalid, 0);
      chk("full_pop_cycle_ydready", s_ydready, 2'b11);
      step(); s_yvalid = 1'b0; #1;
      chk("full_after_pop_valid", s_qvalid, 1);
      step(); r0_qvalid = 1'b0; s_yvalid = 1'b1;
      for (int i = 0; i < 4; i++) step();
      s_yvalid = 1'b0; #1;
      chk("full_drain_busy", busy, 0);

      // enable=0 blocks new starts
      enable = 1'b0; r0_qvalid = 1'b1; #1;
      chk("en0_valid", s_qvalid, 0);
      chk("en0_rdy", r0_qdready, 2'b00);
      enable = 1'b1; r0_qvalid = 1'b0;

      // r1 4-beat write locks out r0 until its last beat; qvalid drop keeps lock
      r1_qvalid = 1'b1; r1_qlast = 1'b0; r1_qdata = 128'hC1; #1;
      chk("lk_b1_r1", r1_qdready, 2'b11);
      step(); r0_qvalid = 1'b1; r0_qlast = 1'b1; r1_qdata = 128'hC2; #1;
      chk("lk_b2_r0", r0_qdready, 2'b00);
      chk("lk_b2_r1", r1_qdready, 2'b11);
      chk("lk_b2_data", s_qdata, 128'hC2);
      chk("lk_b2_busy", busy, 1);
      step(); r1_qvalid = 1'b0; #1;
      chk("lk_drop_valid", s_qvalid, 0);
      chk("lk_drop_r0", r0_qdready, 2'b00);
      step(); r1_qvalid = 1'b1; r1_qdata = 128'hC3; s_qdready = 2'b01; #1;
      chk("lk_b3_r1", r1_qdready, 2'b01);
      chk("lk_b3_r0", r0_qdready, 2'b00);
      step(); s_qdready = 2'b11; r1_qlast = 1'b1; r1_qdata = 128'hC4; #1;
      chk("lk_b4_r0", r0_qdready, 2'b00);
      chk("lk_b4_last", s_qlast, 1);
      step(); r1_qvalid = 1'b0; #1;
      chk("lk_next_r0", r0_qdready, 2'b11);
      chk("lk_next_data", s_qdata, 128'hA0);
      step(); r0_qvalid = 1'b0; s_yvalid = 1'b1; #1;
      chk("lk_reply_r1", r1_yvalid, 1);
      chk("lk_reply_r0", r0_yvalid, 0);
      step(); step(); s_yvalid = 1'b0; #1;
      chk("lk_busy_end", busy, 0);

      // Orphan reply: refused, sticky error, cleared by clear
      s_yvalid = 1'b1; #1;
      chk("orph_ydready", s_ydready, 2'b00);
      chk("orph_r0_yvalid", r0_yvalid, 0);
      chk("orph_r1_yvalid", r1_yvalid, 0);
      step(); s_yvalid = 1'b0; #1;
      chk("orph_err_set", err, 1);
      step(); #1;
      chk("orph_err_sticky", err, 1);
      clear = 1'b1;
      step(); clear = 1'b0; #1;
      chk("orph_err_clear", err, 0);

      // Async reset in the middle of a locked transaction
      r1_qvalid = 1'b1; r1_qlast = 1'b0;
      step(); r0_qvalid = 1'b1; r0_qlast = 1'b1; #1;
      chk("rl_busy_locked", busy, 1);
      rst = 1'b1; #1;
      chk("rl_s_qvalid", s_qvalid, 0);
      chk("rl_r0_rdy", r0_qdready, 2'b00);
      chk("rl_r1_rdy", r1_qdready, 2'b00);
      chk("rl_busy", busy, 0);
      step(); rst = 1'b0; r1_qlast = 1'b1; #1;
      chk("rl_tie_r0", r0_qdready, 2'b11);
      chk("rl_tie_r1", r1_qdready, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
